mem_access_unit: RTL and testbench

Core-side load/store initiator for the `mainmem` word memory. It accepts one byte, halfword or word request at a time from the execute stage and drives `mainmem`'s `address`/`data_in`/`read_write` pins. It returns aligned, sign- or zero-extended load data. Sub-word stores are performed as read-modify-write, because `mainmem` only writes full 32-bit words.

---
 rtl/mem_access_unit.sv | 261 ++++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//
// Core-side load/store initiator for the mainmem word memory. It takes one
// byte, halfword or word request at a time. It drives mainmem's
// address/data_in/read_write pins and returns aligned load data with sign or
// zero extension. mainmem only writes whole 32-bit words, so sub-word stores
// are done as a read-modify-write: the word is read, the addressed lane(s)
// are merged in, and the full word is written back.
//
// Optional build macro:
//   MEM_ACCESS_BOUNDS_CHECK_EN - when defined, a request outside
//   [BASE_ADDR, BASE_ADDR+MEM_DEPTH_BYTES) is rejected with resp_err and
//   produces no memory cycle. When undefined, such addresses go to mainmem
//   unchanged.
//
// Ports:
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_write           1 = store, 0 = load
//   req_size            0 = byte, 1 = half, 2 = word, 3 = illegal
//   req_unsigned        zero-extend the load result
//   req_addr            byte address
//   req_wdata           store data, right-aligned
//   resp_valid          one-cycle completion pulse, no backpressure
//   resp_err            request was rejected (qualifies resp_valid)
//   resp_rdata          load result; 0 for stores and errors
//   mem_address         word-aligned address to mainmem
//   mem_data_in         write data to mainmem
//   mem_data_out        combinational read data from mainmem
//   mem_read_write      0 = read, 1 = write (mainmem writes at posedge)

module mem_access_unit #(
  parameter logic [31:0] BASE_ADDR       = 32'h0100_0000,
  parameter logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_read_write
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_STORE  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] store_data_q, store_data_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        accept_s;
  logic        req_err_s;
  logic        range_err_s;

  // Select the addressed lane of a read word and extend it to 32 bits.
  function automatic logic [31:0] extract_load(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic        uns,
    input logic [1:0]  off
  );
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (size)
      2'd0: res = uns ? {24'h00_0000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'd1: res = uns ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed byte or halfword lane of a word with new data.
  function automatic logic [31:0] merge_lanes(
    input logic [31:0] word,
    input logic [31:0] wdata,
    input logic [1:0]  size,
    input logic [1:0]  off
  );
    logic [31:0] mask;
    logic [31:0] data;
    case (size)
      2'd0: begin
        mask = 32'h0000_00FF << {off, 3'b000};
        data = {24'h00_0000, wdata[7:0]} << {off, 3'b000};
      end
      2'd1: begin
        mask = 32'h0000_FFFF << {off, 3'b000};
        data = {16'h0000, wdata[15:0]} << {off, 3'b000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        data = wdata;
      end
    endcase
    return (word & ~mask) | (data & mask);
  endfunction

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  localparam logic [32:0] MEM_END = {1'b0, BASE_ADDR} + {1'b0, MEM_DEPTH_BYTES};

  // Range check against the window that mainmem actually decodes.
  always_comb begin
    range_err_s = 1'b0;
    if (({1'b0, req_addr} < {1'b0, BASE_ADDR}) || ({1'b0, req_addr} >= MEM_END)) begin
      range_err_s = 1'b1;
    end else begin
      range_err_s = 1'b0;
    end
  end
`else
  // Without the range check the depth parameter has no effect on the logic.
  logic unused_depth_s;
  assign unused_depth_s = ^MEM_DEPTH_BYTES;
  assign range_err_s    = 1'b0;
`endif

  assign accept_s = req_valid && (state_q == S_IDLE);

  // Illegal size, misaligned half/word, or (optionally) out-of-range address.
  always_comb begin
    req_err_s = range_err_s;
    case (req_size)
      2'd1:    if (req_addr[0])          req_err_s = 1'b1; else req_err_s = range_err_s;
      2'd2:    if (req_addr[1:0] != 2'b00) req_err_s = 1'b1; else req_err_s = range_err_s;
      2'd3:    req_err_s = 1'b1;
      default: req_err_s = range_err_s;
    endcase
  end

  // Next-state, request capture and registered-response computation.
  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    store_data_d = store_data_q;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0000_0000;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          if (req_err_s) begin
            state_d    = S_RESP;
            resp_err_d = 1'b1;
          end else if (!req_write) begin
            state_d = S_LOAD;
          end else if (req_size == 2'd2) begin
            // Full-word store needs no read, so its data is ready now.
            state_d      = S_STORE;
            store_data_d = req_wdata;
          end else begin
            state_d = S_RMW_RD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        state_d      = S_RESP;
        resp_rdata_d = extract_load(mem_data_out, size_q, unsigned_q, addr_q[1:0]);
      end
      S_RMW_RD: begin
        state_d      = S_STORE;
        store_data_d = merge_lanes(mem_data_out, wdata_q, size_q, addr_q[1:0]);
      end
      S_STORE: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Response flops are loaded on the edge that enters RESP, so they are
    // high exactly while the FSM sits in RESP.
    resp_valid_d = (state_d == S_RESP);
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      size_q       <= 2'd0;
      unsigned_q   <= 1'b0;
      addr_q       <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      store_data_q <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      store_data_q <= store_data_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // mainmem pins are decoded from the state flop. An asynchronous reset
  // drops read_write at once, so a STORE cut short never writes.
  always_comb begin
    mem_address    = BASE_ADDR;
    mem_data_in    = 32'h0000_0000;
    mem_read_write = 1'b0;
    case (state_q)
      S_LOAD, S_RMW_RD: begin
        mem_address = {addr_q[31:2], 2'b00};
      end
      S_STORE: begin
        mem_address    = {addr_q[31:2], 2'b00};
        mem_data_in    = store_data_q;
        mem_read_write = 1'b1;
      end
      default: begin
        mem_address    = BASE_ADDR;
        mem_data_in    = 32'h0000_0000;
        mem_read_write = 1'b0;
      end
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded testbench for mem_access_unit with a behavioral mainmem.
module tb_mem_access_unit;
  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_read_write;

  always #5 clock = ~clock;

  mem_access_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_err       (resp_err),
    .resp_rdata     (resp_rdata),
    .mem_address    (mem_address),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .mem_read_write (mem_read_write)
  );

  // mainmem model: 256 words at BASE, combinational read, write at posedge.
  logic [31:0] mem [0:255];
  logic [31:0] moff;
  int          wr_count = 0;
  int          cyc = 0;

  always_comb begin
    moff = mem_address - BASE;
    if (mem_address >= BASE && moff < 32'd1024) mem_data_out = mem[moff[9:2]];
    else mem_data_out = 32'h0000_0000;
  end

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mem_read_write) begin
      wr_count <= wr_count + 1;
      if (mem_address >= BASE && (mem_address - BASE) < 32'd1024)
        mem[moff[9:2]] <= mem_data_in;
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          edge_n;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n === 1'b1) begin
      if (resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_edge", cyc + 1, e.edge_n);
        end
      end else begin
        check("resp_idle_zero", {resp_err, resp_rdata[30:0]} | {1'b0, resp_rdata[31], 31'd0}, 32'd0);
      end
    end
  end

  // Issue one request; push its expected response unless told not to.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input int lat,
                       input logic e_err, input logic [31:0] e_rd, input bit track);
    bit ok;
    exp_t e;
    @(negedge clock);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end else begin
      req_write    = wr;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wd;
      req_valid    = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      if (track) begin
        e.err    = e_err;
        e.rdata  = e_rd;
        e.edge_n = cyc + lat;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL resp_timeout: got %0d outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
    mem[4] = 32'h8899_AABB;
    reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_rw", {31'd0, mem_read_write}, 32'd0);
    check("rst_mem_data_in", mem_data_in, 32'd0);
    check("rst_mem_address", mem_address, BASE);
    @(negedge clock);
    reset_n = 1'b1;

    // Loads from the preloaded word 0x8899AABB.
    issue(1'b0, 2'd0, 1'b0, 32'h0100_0011, 32'h0, 2, 1'b0, 32'hFFFF_FFAA, 1'b1);
    issue(1'b0, 2'd0, 1'b1, 32'h0100_0011, 32'h0, 2, 1'b0, 32'h0000_00AA, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 32'h0100_0012, 32'h0, 2, 1'b0, 32'hFFFF_8899, 1'b1);
    issue(1'b0, 2'd1, 1'b1, 32'h0100_0010, 32'h0, 2, 1'b0, 32'h0000_AABB, 1'b1);
    issue(1'b0, 2'd0, 1'b0, 32'h0100_0013, 32'h0, 2, 1'b0, 32'hFFFF_FF88, 1'b1);
    issue(1'b0, 2'd0, 1'b0, 32'h0100_0010, 32'h0, 2, 1'b0, 32'hFFFF_FFBB, 1'b1);
    drain();

    // Reset pulsed while the byte store sits in RMW_RD.
    wc0 = wr_count;
    issue(1'b1, 2'd0, 1'b0, 32'h0100_0012, 32'h0000_005C, 3, 1'b0, 32'h0, 1'b0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort_mem_rw", {31'd0, mem_read_write}, 32'd0);
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("abort_mem_address", mem_address, BASE);
    check("abort_mem_data_in", mem_data_in, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check("abort_no_write", wr_count, wc0);
    issue(1'b0, 2'd2, 1'b0, 32'h0100_0010, 32'h0, 2, 1'b0, 32'h8899_AABB, 1'b1);
    drain();

    // Byte store: one READ, then one WRITE of the merged word.
    wc0 = wr_count;
    issue(1'b1, 2'd0, 1'b0, 32'h0100_0012, 32'hFFFF_FF5C, 3, 1'b0, 32'h0, 1'b1);
    @(negedge clock);
    check("rmw_rd_addr", mem_address, 32'h0100_0010);
    check("rmw_rd_rw", {31'd0, mem_read_write}, 32'd0);
    @(negedge clock);
    check("rmw_wr_rw", {31'd0, mem_read_write}, 32'd1);
    check("rmw_wr_data", mem_data_in, 32'h885C_AABB);
    drain();
    check("rmw_write_count", wr_count - wc0, 32'd1);
    issue(1'b0, 2'd2, 1'b0, 32'h0100_0010, 32'h0, 2, 1'b0, 32'h885C_AABB, 1'b1);
    drain();

    // Word store: immediate WRITE, no READ, then read back.
    wc0 = wr_count;
    issue(1'b1, 2'd2, 1'b0, 32'h0100_0020, 32'hDEAD_BEEF, 2, 1'b0, 32'h0, 1'b1);
    @(negedge clock);
    check("wst_rw", {31'd0, mem_read_write}, 32'd1);
    check("wst_addr", mem_address, 32'h0100_0020);
    check("wst_data", mem_data_in, 32'hDEAD_BEEF);
    drain();
    check("wst_write_count", wr_count - wc0, 32'd1);
    issue(1'b0, 2'd2, 1'b0, 32'h0100_0020, 32'h0, 2, 1'b0, 32'hDEAD_BEEF, 1'b1);
    // Half store into the upper lane, then back-to-back loads.
    issue(1'b1, 2'd1, 1'b0, 32'h0100_0022, 32'h1234_CAFE, 3, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h0100_0020, 32'h0, 2, 1'b0, 32'hCAFE_BEEF, 1'b1);
    issue(1'b0, 2'd1, 1'b1, 32'h0100_0020, 32'h0, 2, 1'b0, 32'h0000_BEEF, 1'b1);
    drain();

    // Rejected requests: no memory cycle, memory unchanged.
    wc0 = wr_count;
    issue(1'b0, 2'd1, 1'b0, 32'h0100_0013, 32'h0, 1, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h0100_0022, 32'h1111_1111, 1, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 2'd3, 1'b0, 32'h0100_0010, 32'h0, 1, 1'b1, 32'h0, 1'b1);
    drain();
    check("err_no_write", wr_count, wc0);
    issue(1'b0, 2'd2, 1'b0, 32'h0100_0020, 32'h0, 2, 1'b0, 32'hCAFE_BEEF, 1'b1);
    drain();

    // Out-of-range word load.
    wc0 = wr_count;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    issue(1'b0, 2'd2, 1'b0, 32'h0200_0000, 32'h0, 1, 1'b1, 32'h0, 1'b1);
    @(negedge clock);
    check("oor_no_read_addr", mem_address, BASE);
`else
    issue(1'b0, 2'd2, 1'b0, 32'h0200_0000, 32'h0, 2, 1'b0, 32'h0, 1'b1);
    @(negedge clock);
    check("oor_read_addr", mem_address, 32'h0200_0000);
    check("oor_read_rw", {31'd0, mem_read_write}, 32'd0);
`endif
    drain();
    check("oor_no_write", wr_count, wc0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
